// File: rtl/i_encoder_4_2_fun_if.sv
// rtl/i_encoder_4_2_fun_if.sv - request/result bundle for the active-low binary encoder
// Optional macro I_ENCODER_ERR_CNT_EN adds the err_cnt signal to the bundle.
interface i_encoder_4_2_fun_if #(
  parameter int SIZE = 2
);
  localparam int N = 2 ** SIZE;

  logic [N-1:0]    a;
  logic [SIZE-1:0] b;
  logic            valid;
  logic            err;
`ifdef I_ENCODER_ERR_CNT_EN
  logic [7:0]      err_cnt;
`endif

  // Encoder side: consumes the active-low select lines, produces the registered result.
  modport slave (
    input  a,
    output b,
    output valid,
`ifdef I_ENCODER_ERR_CNT_EN
    output err_cnt,
`endif
    output err
  );

  // Requester side: drives the select lines, observes the result.
  modport master (
    output a,
    input  b,
    input  valid,
`ifdef I_ENCODER_ERR_CNT_EN
    input  err_cnt,
`endif
    input  err
  );
endinterface

// File: rtl/i_encoder_4_2_fun.sv
// rtl/i_encoder_4_2_fun.sv - registered active-low one-hot to binary encoder (function based)
// Optional macro I_ENCODER_ERR_CNT_EN enables a saturating 8-bit error counter (err_cnt).
module i_encoder_4_2_fun #(
  parameter int SIZE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  i_encoder_4_2_fun_if.slave     bus
);
  localparam int N  = 2 ** SIZE;
  // Zero count can reach N, which needs SIZE+1 bits.
  localparam int CW = SIZE + 1;

  // Returns {zero_count, lowest_zero_index}; index is 0 when no bit is low.
  function automatic logic [CW+SIZE-1:0] enc(input logic [N-1:0] av);
    logic [SIZE-1:0] idx;
    logic [CW-1:0]   cnt;
    idx = '0;
    cnt = '0;
    // Scan from the top so the last hit is the lowest index (bit 0 has priority).
    for (int k = N - 1; k >= 0; k--) begin
      if (!av[k]) begin
        idx = SIZE'(k);
        cnt = cnt + CW'(1);
      end
    end
    return {cnt, idx};
  endfunction

  logic [CW-1:0]   zero_cnt;
  logic [SIZE-1:0] low_idx;

  logic [SIZE-1:0] b_d, b_q;
  logic            valid_d, valid_q;
  logic            err_d, err_q;

  // Next-state selection from the encoded input; b holds when nothing is selected.
  always_comb begin
    {zero_cnt, low_idx} = enc(bus.a);
    b_d     = b_q;
    valid_d = 1'b0;
    err_d   = 1'b1;
    if (zero_cnt == CW'(1)) begin
      b_d     = low_idx;
      valid_d = 1'b1;
      err_d   = 1'b0;
    end else if (zero_cnt != '0) begin
      b_d = low_idx;
    end
  end

  // Result registers; reset dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      b_q     <= b_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.b     = b_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

`ifdef I_ENCODER_ERR_CNT_EN
  logic [7:0] err_cnt_d, err_cnt_q;

  // Count edges that load err=1, saturating at all-ones so the count never wraps.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register; updates on the same edge as err.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_i_encoder_4_2_fun.sv
// tb/tb_i_encoder_4_2_fun.sv - scoreboard bench for i_encoder_4_2_fun (SIZE=2)
module tb_i_encoder_4_2_fun;
  logic clk;
  logic rst;

  i_encoder_4_2_fun_if #(.SIZE(2)) bus ();

  i_encoder_4_2_fun #(.SIZE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] b;
    logic       valid;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one input at the falling edge and queue what the next rising edge must produce.
  task automatic step(input logic r, input logic [3:0] av, input logic [1:0] eb,
                      input logic ev, input logic ee, input logic [7:0] ec);
    exp_t e;
    @(negedge clk);
    rst   = r;
    bus.a = av;
    e.b = eb; e.valid = ev; e.err = ee; e.cnt = ec;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge produces a result; compare it against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("b", 32'(bus.b), 32'(e.b));
        check("valid", 32'(bus.valid), 32'(e.valid));
        check("err", 32'(bus.err), 32'(e.err));
`ifdef I_ENCODER_ERR_CNT_EN
        check("err_cnt", 32'(bus.err_cnt), 32'(e.cnt));
`endif
      end
    end
  end

  // Stimulus: directed vectors, expected values worked out by hand.
  initial begin
    int wait_cyc;
    rst   = 1'b1;
    bus.a = 4'b1111;
    //    rst  a        b     v     e     cnt
    step(1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 4'b1110, 2'd0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 8'd0);
    step(1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 8'd0);
    step(1'b0, 4'b0111, 2'd3, 1'b1, 1'b0, 8'd0);
    step(1'b0, 4'b1111, 2'd3, 1'b0, 1'b1, 8'd1);
    step(1'b0, 4'b1010, 2'd0, 1'b0, 1'b1, 8'd2);
    step(1'b0, 4'b0011, 2'd2, 1'b0, 1'b1, 8'd3);
    step(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 8'd4);
    step(1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 8'd4);
    step(1'b1, 4'b1011, 2'd0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 8'd0);
    step(1'b0, 4'b1111, 2'd2, 1'b0, 1'b1, 8'd1);
    step(1'b0, 4'b0111, 2'd3, 1'b1, 1'b0, 8'd1);
    step(1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 4'b1111, 2'd0, 1'b0, 1'b1, 8'd1);
    step(1'b0, 4'b0101, 2'd1, 1'b0, 1'b1, 8'd2);
    // 300 consecutive error cycles: counter climbs from 2 and saturates at FF; b holds 1.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 4'b1111, 2'd1, 1'b0, 1'b1, (i + 3 >= 255) ? 8'hFF : 8'(i + 3));
    end
    step(1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 8'd0);
    stim_done = 1'b1;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so a stuck run still reports.
  initial begin
    #100000;
    $display("FAIL timeout: got stim_done=%0d expected 1", stim_done);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
